// File: rtl/dircc_counter_pkg.sv
// Shared constants for the DIRCC processing-counter CSR block: register map,
// CTRL/STATUS bit positions, read latency and a byte-lane merge helper.
package dircc_counter_pkg;

  localparam int          READ_LATENCY     = 2;
  localparam logic [31:0] ID_VALUE_DEFAULT = 32'hD1CC_0001;

  localparam logic [2:0] ADDR_CTRL     = 3'd0;
  localparam logic [2:0] ADDR_STATUS   = 3'd1;
  localparam logic [2:0] ADDR_COUNT_LO = 3'd2;
  localparam logic [2:0] ADDR_COUNT_HI = 3'd3;
  localparam logic [2:0] ADDR_TERM_LO  = 3'd4;
  localparam logic [2:0] ADDR_TERM_HI  = 3'd5;
  localparam logic [2:0] ADDR_ID       = 3'd6;

  localparam int CTRL_ENABLE    = 0;
  localparam int CTRL_CLEAR     = 1;
  localparam int CTRL_IRQ_EN    = 2;

  localparam int STATUS_RUNNING  = 0;
  localparam int STATUS_TERM_HIT = 1;
  localparam int STATUS_WRAPPED  = 2;

  // Byte lanes with a low enable keep the old register byte.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  be);
    logic [31:0] result;
    for (int i = 0; i < 4; i++) begin
      result[8*i +: 8] = be[i] ? new_val[8*i +: 8] : old_val[8*i +: 8];
    end
    return result;
  endfunction

endpackage

// File: rtl/dircc_csr_read_pipe.sv
// Fixed-latency read response pipeline: carries read data captured in the
// accept cycle and its valid strobe through DEPTH register stages.
module dircc_csr_read_pipe
  import dircc_counter_pkg::*;
#(
  parameter int DEPTH = READ_LATENCY
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [31:0] in_data,
  output logic        out_valid,
  output logic [31:0] out_data
);

  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] valid_d;
  logic [31:0]      data_q [DEPTH];
  logic [31:0]      data_d [DEPTH];

  // NOTE: every variable assigned in always_comb gets a value on every path,
  // otherwise synthesis infers a latch.
  always_comb begin
    valid_d   = {valid_q[DEPTH-2:0], in_valid};
    data_d[0] = in_valid ? in_data : '0;
    for (int i = 1; i < DEPTH; i++) begin
      data_d[i] = data_q[i-1];
    end
  end

  // NOTE: the data stages are reset too so readdata is 0 whenever no response
  // is being presented, including immediately after reset discards a response.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= data_d[i];
      end
    end
  end

  assign out_valid = valid_q[DEPTH-1];
  assign out_data  = data_q[DEPTH-1];

endmodule

// File: rtl/dircc_counter_csr_responder.sv
// Avalon-MM CSR responder for the processing-counter test state: event counter,
// terminal compare, sticky status, coherent 64-bit count reads and an interrupt.
module dircc_counter_csr_responder
  import dircc_counter_pkg::*;
#(
  parameter int          COUNT_W  = 64,
  parameter logic [31:0] ID_VALUE = ID_VALUE_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        count_tick,
  input  logic [2:0]  avs_address,
  input  logic        avs_read,
  input  logic        avs_write,
  input  logic [31:0] avs_writedata,
  input  logic [3:0]  avs_byteenable,
  output logic        avs_waitrequest,
  output logic [31:0] avs_readdata,
  output logic        avs_readdatavalid,
  output logic        irq
);

  localparam int                 HI_W       = COUNT_W - 32;
  localparam logic [COUNT_W-1:0] COUNT_ONES = '1;
  localparam logic [COUNT_W-1:0] COUNT_ONE  = COUNT_W'(1);

  logic               boot_q, settle_q, settle_d;
  logic               enable_q, enable_d;
  logic               irq_en_q, irq_en_d;
  logic               term_hit_q, term_hit_d;
  logic               wrapped_q, wrapped_d;
  logic               irq_q, irq_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic [COUNT_W-1:0] term_q, term_d;
  logic [31:0]        shadow_q, shadow_d;

  logic               write_acc, read_acc;
  logic               clear_pulse, term_w1c, wrap_w1c;
  logic               term_set, wrap_set, load_count;
  logic [COUNT_W-1:0] count_load;
  logic [31:0]        count_hi32, term_hi32, hi_merged;
  logic [31:0]        read_data;

  // Stall for the first cycle out of reset and for one settle cycle after CTRL writes.
  assign avs_waitrequest = (boot_q & ~reset) | settle_q;

  // A write wins over a simultaneous read; the read is dropped.
  assign write_acc = avs_write & ~avs_waitrequest;
  assign read_acc  = avs_read & ~avs_write & ~avs_waitrequest;

  always_comb begin
    count_hi32 = '0;
    term_hi32  = '0;
    count_hi32[HI_W-1:0] = count_q[COUNT_W-1:32];
    term_hi32[HI_W-1:0]  = term_q[COUNT_W-1:32];
  end

  // Register write decode.
  always_comb begin
    enable_d    = enable_q;
    irq_en_d    = irq_en_q;
    clear_pulse = 1'b0;
    term_w1c    = 1'b0;
    wrap_w1c    = 1'b0;
    term_d      = term_q;
    load_count  = 1'b0;
    count_load  = count_q;
    hi_merged   = '0;
    if (write_acc) begin
      case (avs_address)
        ADDR_CTRL: begin
          if (avs_byteenable[0]) begin
            enable_d    = avs_writedata[CTRL_ENABLE];
            irq_en_d    = avs_writedata[CTRL_IRQ_EN];
            clear_pulse = avs_writedata[CTRL_CLEAR];
          end
        end
        ADDR_STATUS: begin
          if (avs_byteenable[0]) begin
            term_w1c = avs_writedata[STATUS_TERM_HIT];
            wrap_w1c = avs_writedata[STATUS_WRAPPED];
          end
        end
        ADDR_COUNT_LO: begin
          load_count       = 1'b1;
          count_load[31:0] = merge_bytes(count_q[31:0], avs_writedata, avs_byteenable);
        end
        ADDR_COUNT_HI: begin
          load_count                 = 1'b1;
          hi_merged                  = merge_bytes(count_hi32, avs_writedata, avs_byteenable);
          count_load[COUNT_W-1:32]   = hi_merged[HI_W-1:0];
        end
        ADDR_TERM_LO: begin
          term_d[31:0] = merge_bytes(term_q[31:0], avs_writedata, avs_byteenable);
        end
        ADDR_TERM_HI: begin
          hi_merged              = merge_bytes(term_hi32, avs_writedata, avs_byteenable);
          term_d[COUNT_W-1:32]   = hi_merged[HI_W-1:0];
        end
        default: ;
      endcase
    end
  end

  // Counter: terminal hit beats wrap; clear beats counting; a direct load beats both.
  always_comb begin
    count_d  = count_q;
    term_set = 1'b0;
    wrap_set = 1'b0;
    if (enable_q && count_tick) begin
      if (count_q == term_q) begin
        count_d  = '0;
        term_set = 1'b1;
      end else if (count_q == COUNT_ONES) begin
        count_d  = '0;
        wrap_set = 1'b1;
      end else begin
        count_d = count_q + COUNT_ONE;
      end
    end
    if (clear_pulse) count_d = '0;
    if (load_count)  count_d = count_load;
  end

  always_comb begin
    term_hit_d = term_set | (term_hit_q & ~term_w1c);
    wrapped_d  = wrap_set | (wrapped_q & ~wrap_w1c);
    irq_d      = irq_en_q & (term_hit_q | wrapped_q);
    settle_d   = write_acc && (avs_address == ADDR_CTRL);
    shadow_d   = (read_acc && (avs_address == ADDR_COUNT_LO)) ? count_hi32 : shadow_q;
  end

  always_comb begin
    read_data = '0;
    case (avs_address)
      ADDR_CTRL: begin
        read_data[CTRL_ENABLE] = enable_q;
        read_data[CTRL_IRQ_EN] = irq_en_q;
      end
      ADDR_STATUS: begin
        read_data[STATUS_RUNNING]  = enable_q;
        read_data[STATUS_TERM_HIT] = term_hit_q;
        read_data[STATUS_WRAPPED]  = wrapped_q;
      end
      ADDR_COUNT_LO: read_data = count_q[31:0];
      ADDR_COUNT_HI: read_data = shadow_q;
      ADDR_TERM_LO:  read_data = term_q[31:0];
      ADDR_TERM_HI:  read_data = term_hi32;
      ADDR_ID:       read_data = ID_VALUE;
      default:       read_data = '0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      boot_q     <= 1'b1;
      settle_q   <= 1'b0;
      enable_q   <= 1'b0;
      irq_en_q   <= 1'b0;
      term_hit_q <= 1'b0;
      wrapped_q  <= 1'b0;
      irq_q      <= 1'b0;
      count_q    <= '0;
      term_q     <= '1;
      shadow_q   <= '0;
    end else begin
      boot_q     <= 1'b0;
      settle_q   <= settle_d;
      enable_q   <= enable_d;
      irq_en_q   <= irq_en_d;
      term_hit_q <= term_hit_d;
      wrapped_q  <= wrapped_d;
      irq_q      <= irq_d;
      count_q    <= count_d;
      term_q     <= term_d;
      shadow_q   <= shadow_d;
    end
  end

  assign irq = irq_q;

  dircc_csr_read_pipe #(
    .DEPTH(READ_LATENCY)
  ) u_read_pipe (
    .clk      (clk),
    .reset    (reset),
    .in_valid (read_acc),
    .in_data  (read_data),
    .out_valid(avs_readdatavalid),
    .out_data (avs_readdata)
  );

  // Read and write together is an initiator protocol violation.
  a_no_rd_wr: assert property (@(posedge clk) disable iff (reset) !(avs_read && avs_write));

endmodule
